calc_input_seq: RTL and testbench
=================================

CALC_INPUT_SEQ -- requirements
Module: calc_input_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizers for load_btn and clr_btn; legal values 2..3.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: consecutive stable cycles required by the debouncer; legal values 1..65535.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  block enable; when low, the FSM and all capture registers hold.
REQ-006 data_in  input  8  operand/opcode entry switches; sampled only on a load pulse.
REQ-007 load_btn  input  1  raw, asynchronous load push-button, active-high.
REQ-008 clr_btn  input  1  raw, asynchronous clear push-button, active-high.
REQ-009 calc_out  output  8  packed word to the calculator: {op[1:0], b[2:0], a[2:0]}.
REQ-010 calc_valid  output  1  high while calc_out holds a complete, current operand set.
REQ-011 state  output  2  current FSM state, for status LEDs.

Function
REQ-012 The FSM SHALL have four states: S_A=0 (expect A), S_B=1, S_OP=2, S_READY=3.
REQ-013 A load pulse SHALL be a single-cycle strobe on the rising edge of the conditioned load level (see REQ-024).
REQ-014 In S_A a load pulse SHALL capture data_in[2:0] into a and go to S_B.
REQ-015 In S_B a load pulse SHALL capture data_in[2:0] into b and go to S_OP.
REQ-016 In S_OP a load pulse SHALL capture data_in[1:0] into op and go to S_READY.
REQ-017 On the S_OP->S_READY transition, calc_out SHALL update and calc_valid SHALL rise on the same clock edge.
REQ-018 In S_READY a load pulse SHALL capture data_in[2:0] as a new a, clear calc_valid and go to S_B.
REQ-019 calc_out SHALL hold the last complete set until the next S_OP->S_READY transition.
REQ-020 data_in bits not named in REQ-014..REQ-016 SHALL be ignored.
REQ-021 A synchronized clr_btn high SHALL force S_A, zero a, b, op and calc_out, and clear calc_valid on the next edge; clear takes priority over a simultaneous load pulse, and that load pulse is discarded.
REQ-022 With ena low, state, registers and outputs SHALL hold; load pulses arriving during ena low SHALL be lost, and clear SHALL still act.
REQ-023 Without debounce, latency from a load_btn rise to the capture edge SHALL be SYNC_STAGES+1 cycles.
REQ-024 The conditioned load level SHALL be the synchronized level, or the debounced level when CALC_SEQ_DEBOUNCE_EN is defined.

Reset
REQ-025 Reset SHALL set state=S_A, a=b=op=0, calc_out=8'h00, calc_valid=0, clear all synchronizer flops, clear the debounce counter, and set the edge-detect history to 0.
REQ-026 Deassertion of rst_n in the middle of a sequence SHALL restart entry at S_A, and a button already held at release SHALL NOT generate a load pulse until it is released and pressed again.

Configuration
REQ-027 Macro CALC_SEQ_DEBOUNCE_EN defined: the debounced level SHALL toggle only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement SHALL reset the counter.
REQ-028 Macro CALC_SEQ_DEBOUNCE_EN undefined: the synchronized level SHALL feed the edge detector directly, and no counter logic SHALL be synthesized.

Structure
REQ-029 Package calc_pkg SHALL hold the state enum, the operand width (3), the op width (2), the op encoding (ADD=0, SUB=1, AND=2, OR=3) and the calc_out field offsets.
REQ-030 Sub-module calc_debounce (synchronizer + optional debounce + rising-edge detect) SHALL be instantiated once for load_btn; clr_btn SHALL use a synchronizer only.

Verification
REQ-031 No debounce: load pulses with data_in=05, 03, 01 -> calc_out=8'h5D, calc_valid=1, state=3, with each capture SYNC_STAGES+1 cycles after its press.
REQ-032 From S_READY, load data_in=02 -> state=1, calc_valid=0, calc_out still 8'h5D.
REQ-033 Clear and load asserted in the same synchronized cycle while in S_OP -> state=0, calc_out=00, calc_valid=0, no capture.
REQ-034 ena=0 with three load presses -> state, calc_out and calc_valid unchanged; ena=1 with one press -> exactly one capture.
REQ-035 Debounce on, DEBOUNCE_CYCLES=4: a 3-cycle glitch -> no capture; a clean press held 10 cycles -> exactly one capture, 4 cycles after synchronization.
REQ-036 Reset asserted mid-sequence with load_btn held, then released -> all outputs 0, state 0, and no capture until load_btn falls and rises again.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and field layout for the calculator input sequencer.
package calc_pkg;

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_OP    = 2'd2,
    S_READY = 2'd3
  } state_t;

  localparam int OPND_W = 3;
  localparam int OP_W   = 2;
  localparam int CALC_W = 2 * OPND_W + OP_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_t;

  localparam int A_LSB  = 0;
  localparam int B_LSB  = OPND_W;
  localparam int OP_LSB = 2 * OPND_W;

  function automatic logic [CALC_W-1:0] pack_calc(input op_t op,
                                                   input logic [OPND_W-1:0] b,
                                                   input logic [OPND_W-1:0] a);
    logic [CALC_W-1:0] word;
    word = '0;
    word[OP_LSB +: OP_W]  = op;
    word[B_LSB +: OPND_W] = b;
    word[A_LSB +: OPND_W] = a;
    return word;
  endfunction

endpackage

// File: rtl/calc_debounce.sv
// Button conditioner: synchronizer, optional debounce (CALC_SEQ_DEBOUNCE_EN), rising-edge strobe.
module calc_debounce
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] settle;
  logic                   sync_level;
  logic                   level;
  logic                   hist;
  logic                   armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      settle <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], btn};
      settle <= {settle[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_level = sync[SYNC_STAGES-1];

`ifdef CALC_SEQ_DEBOUNCE_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] cnt;
  logic             deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync_level == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      deb <= sync_level;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = deb;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign level = sync_level;
`endif

  // A button held through reset must be seen released (once the chain holds
  // post-reset samples) before any rising edge is honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= 1'b0;
      armed <= 1'b0;
    end else begin
      hist  <= level;
      armed <= armed | (settle[SYNC_STAGES-1] & ~sync_level);
    end
  end

  assign rise = level & ~hist & armed;

endmodule

// File: rtl/calc_input_seq.sv
// Calculator operand/opcode entry sequencer: A, B, OP captured on successive load presses.
// Optional load-button debounce enabled by defining CALC_SEQ_DEBOUNCE_EN.
module calc_input_seq
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       load_btn,
  input  logic       clr_btn,
  output logic [7:0] calc_out,
  output logic       calc_valid,
  output logic [1:0] state
);

  logic                   load_pulse;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                   clr;
  state_t                 state_q;
  state_t                 state_d;
  logic                   cap_a;
  logic                   cap_b;
  logic                   cap_op;
  logic [OPND_W-1:0]      a;
  logic [OPND_W-1:0]      b;
  logic                   unused_data_bits;

  assign unused_data_bits = ^data_in[7:3];

  calc_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_deb (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (load_btn),
    .rise (load_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_sync <= '0;
    else        clr_sync <= {clr_sync[SYNC_STAGES-2:0], clr_btn};
  end

  assign clr = clr_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_A;
    else        state_q <= state_d;
  end

  // Clear wins over load and ignores ena; a load pulse while disabled is dropped.
  always_comb begin
    state_d = state_q;
    cap_a   = 1'b0;
    cap_b   = 1'b0;
    cap_op  = 1'b0;
    if (clr) begin
      state_d = S_A;
    end else if (ena && load_pulse) begin
      case (state_q)
        S_A:     begin cap_a  = 1'b1; state_d = S_B;     end
        S_B:     begin cap_b  = 1'b1; state_d = S_OP;    end
        S_OP:    begin cap_op = 1'b1; state_d = S_READY; end
        S_READY: begin cap_a  = 1'b1; state_d = S_B;     end
        default: state_d = S_A;
      endcase
    end
  end

  // op has no working copy: it is captured straight into calc_out with a and b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= '0;
      b          <= '0;
      calc_out   <= '0;
      calc_valid <= 1'b0;
    end else if (clr) begin
      a          <= '0;
      b          <= '0;
      calc_out   <= '0;
      calc_valid <= 1'b0;
    end else begin
      if (cap_a) begin
        a          <= data_in[OPND_W-1:0];
        calc_valid <= 1'b0;
      end
      if (cap_b) b <= data_in[OPND_W-1:0];
      if (cap_op) begin
        calc_out   <= pack_calc(op_t'(data_in[OP_W-1:0]), b, a);
        calc_valid <= 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_calc_input_seq.sv
// Self-checking bench for calc_input_seq: vector table, hand-written corner cases, random vs queue model.
module tb_calc_input_seq;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
`ifdef CALC_SEQ_DEBOUNCE_EN
  localparam int LAT = SYNC + DEB + 1;
`else
  localparam int LAT = SYNC + 1;
`endif
  localparam int REL = LAT + 3;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] data_in;
  logic       load_btn;
  logic       clr_btn;
  logic [7:0] calc_out;
  logic       calc_valid;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  calc_input_seq #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .data_in   (data_in),
    .load_btn  (load_btn),
    .clr_btn   (clr_btn),
    .calc_out  (calc_out),
    .calc_valid(calc_valid),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: entries collected so far in the current operand set.
  logic [2:0] q[$];
  logic [7:0] m_out;
  logic       m_valid;

  function automatic void model_clear();
    q.delete();
    m_out   = 8'h00;
    m_valid = 1'b0;
  endfunction

  function automatic void model_load(input logic [7:0] d);
    if (q.size() == 3) begin
      q.delete();
      m_valid = 1'b0;
    end
    q.push_back(d[2:0]);
    if (q.size() == 3) begin
      m_out   = {q[2][1:0], q[1], q[0]};
      m_valid = 1'b1;
    end
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [1:0] st, input logic [7:0] out,
                         input logic vld);
    chk({nm, "_state"}, {6'd0, state}, {6'd0, st});
    chk({nm, "_out"}, calc_out, out);
    chk({nm, "_valid"}, {7'd0, calc_valid}, {7'd0, vld});
  endtask

  task automatic chk_model(input string nm);
    chk_all(nm, 2'(q.size()), m_out, m_valid);
  endtask

  task automatic press(input logic [7:0] d, input int hold);
    @(negedge clk);
    data_in  = d;
    load_btn = 1'b1;
    repeat (hold) @(negedge clk);
    load_btn = 1'b0;
    data_in  = 8'($urandom);
    repeat (REL) @(negedge clk);
  endtask

  task automatic clear_press();
    @(negedge clk);
    clr_btn = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    clr_btn = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [1:0] st;
    logic [7:0] out;
    logic       vld;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] pst;
    logic [7:0] pout;
    logic       pvld;

    vecs[0] = '{8'h05, 2'd1, 8'h00, 1'b0};
    vecs[1] = '{8'h03, 2'd2, 8'h00, 1'b0};
    vecs[2] = '{8'h01, 2'd3, 8'h5D, 1'b1};
    vecs[3] = '{8'h02, 2'd1, 8'h5D, 1'b0};
    vecs[4] = '{8'hAF, 2'd2, 8'h5D, 1'b0};
    vecs[5] = '{8'hCE, 2'd3, 8'hBA, 1'b1};

    rst_n    = 1'b0;
    ena      = 1'b1;
    data_in  = 8'h00;
    load_btn = 1'b0;
    clr_btn  = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 2'd0, 8'h00, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Capture latency and packing, including ignored upper data bits.
    pst = 2'd0; pout = 8'h00; pvld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_in  = vecs[i].d;
      load_btn = 1'b1;
      repeat (LAT - 1) @(negedge clk);
      chk_all($sformatf("vec%0d_early", i), pst, pout, pvld);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].out, vecs[i].vld);
      repeat (2) @(negedge clk);
      load_btn = 1'b0;
      repeat (REL) @(negedge clk);
      pst = vecs[i].st; pout = vecs[i].out; pvld = vecs[i].vld;
    end

    // Clear and load together while in S_OP.
    press(8'h03, LAT + 2);
    press(8'h04, LAT + 2);
    chk_all("pre_clr", 2'd2, 8'hBA, 1'b0);
    @(negedge clk);
    data_in  = 8'h03;
    load_btn = 1'b1;
    clr_btn  = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    chk_all("clr_load", 2'd0, 8'h00, 1'b0);
    repeat (LAT + 2) @(negedge clk);
    load_btn = 1'b0;
    clr_btn  = 1'b0;
    repeat (REL) @(negedge clk);
    chk_all("clr_no_capture", 2'd0, 8'h00, 1'b0);
    press(8'h01, LAT + 2);
    press(8'h02, LAT + 2);
    press(8'h03, LAT + 2);
    chk_all("after_clr_set", 2'd3, 8'hD1, 1'b1);

    // Enable low: presses lost, clear still acts.
    @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) press(8'h05, LAT + 2);
    chk_all("ena_low", 2'd3, 8'hD1, 1'b1);
    @(negedge clk);
    ena = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    chk_all("ena_rise_no_pending", 2'd3, 8'hD1, 1'b1);
    press(8'h06, LAT + 2);
    chk_all("ena_one_capture", 2'd1, 8'hD1, 1'b0);
    @(negedge clk);
    ena = 1'b0;
    clear_press();
    chk_all("ena_low_clear", 2'd0, 8'h00, 1'b0);
    ena = 1'b1;

    // Reset mid-sequence with load held through release.
    press(8'h07, LAT + 2);
    press(8'h01, LAT + 2);
    press(8'h02, LAT + 2);
    chk_all("pre_rst_set", 2'd3, 8'h8F, 1'b1);
    press(8'h04, LAT + 2);
    @(negedge clk);
    load_btn = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 6) @(negedge clk);
    chk_all("held_no_pulse", 2'd0, 8'h00, 1'b0);
    load_btn = 1'b0;
    repeat (REL) @(negedge clk);
    chk_all("release_no_pulse", 2'd0, 8'h00, 1'b0);
    press(8'h03, LAT + 2);
    chk_all("repress", 2'd1, 8'h00, 1'b0);

`ifdef CALC_SEQ_DEBOUNCE_EN
    // Short glitch rejected; clean press captured after the debounce interval.
    @(negedge clk);
    data_in  = 8'h06;
    load_btn = 1'b1;
    repeat (3) @(negedge clk);
    load_btn = 1'b0;
    repeat (REL) @(negedge clk);
    chk_all("glitch", 2'd1, 8'h00, 1'b0);
    @(negedge clk);
    data_in  = 8'h06;
    load_btn = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    chk_all("deb_early", 2'd1, 8'h00, 1'b0);
    @(negedge clk);
    chk_all("deb_capture", 2'd2, 8'h00, 1'b0);
    repeat (10 - LAT) @(negedge clk);
    load_btn = 1'b0;
    repeat (REL) @(negedge clk);
    chk_all("deb_once", 2'd2, 8'h00, 1'b0);
`endif

    // Random presses and clears against the queue model.
    clear_press();
    model_clear();
    chk_model("rand_start");
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        clear_press();
        model_clear();
      end else begin
        logic [7:0] d;
        d = 8'($urandom);
        press(d, LAT + int'($urandom_range(0, 4)));
        model_load(d);
      end
      chk_model($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
